// File: rtl/decade_disp_pkg.sv
// rtl/decade_disp_pkg.sv - shared types, segment constants and BCD decode for the decade display driver
package decade_disp_pkg;

   typedef logic [3:0] bcd_t;

   // Segment order is {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit of the accumulated count with combinational carry out
module bcd_digit_cell
   import decade_disp_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic carry_out,
   output bcd_t digit
);

   // Carry is combinational so a whole 9..9 run rolls over in the event's cycle.
   assign carry_out = inc & (digit == 4'd9);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         digit <= 4'd0;
      end else if (inc) begin
         digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/decade_display_driver.sv
// rtl/decade_display_driver.sv - accumulates decade-counter wraps and scans all digits onto a 7-segment display
module decade_display_driver
   import decade_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int BLANK_LZ   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            count_in,
   input  logic                  ten_in,
   input  logic                  clr,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  overflow
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   logic                  ten_d;
   logic                  ten_evt;
   logic [NUM_DIGITS-1:1] inc;
   logic [NUM_DIGITS-1:1] carry;
   bcd_t [NUM_DIGITS-1:1] digits;
   logic [NUM_DIGITS-1:1] blank;
   logic                  all_zero;
   logic                  sel_blank;
   bcd_t                  sel_digit;
   logic [CW-1:0]         scan_cnt;
   logic [IW-1:0]         scan_idx;
   logic [6:0]            next_seg;

   // ten_d tracks ten_in even through reset, so a level held across reset release is not an edge.
   always_ff @(posedge clk) begin
      ten_d <= ten_in;
   end

   assign ten_evt = ten_in & ~ten_d;

   genvar k;
   generate
      for (k = 1; k < NUM_DIGITS; k++) begin : g_digit
         if (k == 1) begin : g_first
            assign inc[k] = ten_evt;
         end else begin : g_chain
            assign inc[k] = carry[k-1];
         end
         bcd_digit_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .inc       (inc[k]),
            .carry_out (carry[k]),
            .digit     (digits[k])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         overflow <= 1'b0;
      end else if (carry[NUM_DIGITS-1]) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // A digit is a leading zero when it and everything above it are zero.
   always_comb begin
      blank     = '0;
      all_zero  = 1'b1;
      sel_blank = 1'b0;
      sel_digit = 4'd0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero & (digits[i] == 4'd0);
         blank[i] = all_zero;
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (scan_idx == IW'(i)) begin
            sel_digit = digits[i];
            sel_blank = blank[i];
         end
      end
      if (scan_idx == '0) begin
         next_seg = bcd_to_seg(count_in);
      end else if ((BLANK_LZ != 0) && sel_blank) begin
         next_seg = SEG_BLANK;
      end else begin
         next_seg = bcd_to_seg(sel_digit);
      end
   end

   // Blanked digits keep their anode enabled so every slot has the same duty cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= '1;
         seg <= SEG_BLANK;
      end else begin
         an  <= ~(NUM_DIGITS'(1) << scan_idx);
         seg <= next_seg;
      end
   end

endmodule

// File: tb/tb_decade_display_driver.sv
// tb/tb_decade_display_driver.sv - randomized self-checking bench for decade_display_driver
module tb_decade_display_driver;

   localparam int NUM_DIGITS = 4;
   localparam int SCAN_DIV   = 4;
   localparam int BLANK_LZ   = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] count_in = 4'd0;
   logic       ten_in = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       overflow;

   int errors = 0;
   int checks = 0;

   // Reference model: the accumulated digits as one integer 0..999 plus cycles since reset.
   int         m_acc = 0;
   logic       m_ovf = 1'b0;
   int         m_n = 0;
   logic       m_ten_d = 1'b0;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_ovf;

   decade_display_driver #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV),
      .BLANK_LZ   (BLANK_LZ)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .count_in (count_in),
      .ten_in   (ten_in),
      .clr      (clr),
      .an       (an),
      .seg      (seg),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic int pow10(input int e);
      int p = 1;
      for (int i = 0; i < e; i++) p = p * 10;
      return p;
   endfunction

   // Drive one cycle of inputs, predict the outputs after the coming edge, advance the model.
   task automatic step(input logic r, input logic t, input logic [3:0] c, input logic cl);
      int idx;
      @(negedge clk);
      rst = r; ten_in = t; count_in = c; clr = cl;
      if (r) begin
         exp_an  = 4'b1111;
         exp_seg = 7'h7F;
         m_acc = 0; m_ovf = 1'b0; m_n = 0;
      end else begin
         idx = (m_n / SCAN_DIV) % NUM_DIGITS;
         exp_an = ~(4'b0001 << idx);
         if (idx == 0)
            exp_seg = seg_of(int'(c));
         else if (BLANK_LZ != 0 && m_acc < pow10(idx - 1))
            exp_seg = 7'h7F;
         else
            exp_seg = seg_of((m_acc / pow10(idx - 1)) % 10);
         if (cl) begin
            m_acc = 0; m_ovf = 1'b0;
         end else if (t && !m_ten_d) begin
            if (m_acc == 999) begin
               m_acc = 0; m_ovf = 1'b1;
            end else begin
               m_acc = m_acc + 1;
            end
         end
         m_n = m_n + 1;
      end
      m_ten_d = t;
      exp_ovf = m_ovf;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 4'd0, 1'b0);
         checks++;
         if (an !== 4'b1111 || seg !== 7'h7F || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: an=%b seg=%b ovf=%b, want an=1111 seg=1111111 ovf=0", an, seg, overflow);
         end
      end
      step(1'b0, 1'b0, 4'd3, 1'b0);
      checks++;
      if (an !== 4'b1110 || seg !== 7'b0110000) begin
         errors++;
         $display("FAIL reset_exit: an=%b seg=%b, want an=1110 seg=0110000", an, seg);
      end
   endtask

   task automatic test_pulses;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, (i % 2) == 0, 4'($urandom_range(0, 9)), 1'b0);
         checks++;
         if (an !== exp_an || seg !== exp_seg || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL pulses[%0d]: an=%b seg=%b ovf=%b, want %b %b %b", i, an, seg, overflow, exp_an, exp_seg, exp_ovf);
         end
      end
      for (int i = 0; i < 16 && exp_an !== 4'b1101; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (an !== 4'b1101 || seg !== 7'b1000000) begin
         errors++;
         $display("FAIL pulses_digit1: an=%b seg=%b, want an=1101 seg=1000000", an, seg);
      end
      for (int i = 0; i < 16 && exp_an !== 4'b0111; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (an !== 4'b0111 || seg !== 7'b1111111) begin
         errors++;
         $display("FAIL pulses_digit3: an=%b seg=%b, want an=0111 seg=1111111", an, seg);
      end
   endtask

   task automatic test_hold;
      step(1'b0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, i < 5, 4'd1, 1'b0);
         checks++;
         if (an !== exp_an || seg !== exp_seg || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL hold[%0d]: an=%b seg=%b ovf=%b, want %b %b %b", i, an, seg, overflow, exp_an, exp_seg, exp_ovf);
         end
      end
      for (int i = 0; i < 16 && exp_an !== 4'b1101; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (seg !== 7'b1111001) begin
         errors++;
         $display("FAIL hold_once: seg=%b, want 1111001", seg);
      end
      step(1'b1, 1'b1, 4'd0, 1'b0);
      step(1'b1, 1'b1, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd0, 1'b0);
      for (int i = 0; i < 16 && exp_an !== 4'b1101; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (an !== 4'b1101 || seg !== 7'b1111111) begin
         errors++;
         $display("FAIL ten_through_reset: an=%b seg=%b, want an=1101 seg=1111111", an, seg);
      end
   endtask

   task automatic test_overflow;
      step(1'b0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 999; i++) begin
         step(1'b0, 1'b1, 4'd0, 1'b0);
         step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
         checks++;
         if (an !== exp_an || seg !== exp_seg || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL count[%0d]: an=%b seg=%b ovf=%b, want %b %b %b", i, an, seg, overflow, exp_an, exp_seg, exp_ovf);
         end
      end
      for (int i = 0; i < 16 && exp_an !== 4'b0111; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (overflow !== 1'b0 || seg !== 7'b0010000) begin
         errors++;
         $display("FAIL at_999: ovf=%b seg=%b, want ovf=0 seg=0010000", overflow, seg);
      end
      step(1'b0, 1'b1, 4'd0, 1'b0);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set: ovf=%b, want 1", overflow);
      end
      step(1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 4'd0, 1'b0);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: ovf=%b, want 1", overflow);
      end
   endtask

   task automatic test_decode;
      for (int i = 0; i < 16 && exp_an !== 4'b0111; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd7, 1'b0);
      checks++;
      if (an !== 4'b1110 || seg !== 7'b1111000) begin
         errors++;
         $display("FAIL decode_7: an=%b seg=%b, want an=1110 seg=1111000", an, seg);
      end
      step(1'b0, 1'b0, 4'hC, 1'b0);
      checks++;
      if (an !== 4'b1110 || seg !== 7'b0111111) begin
         errors++;
         $display("FAIL decode_dash: an=%b seg=%b, want an=1110 seg=0111111", an, seg);
      end
   endtask

   task automatic test_clr_event;
      step(1'b0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 4'd0, 1'b0);
         step(1'b0, 1'b0, 4'd0, 1'b0);
      end
      step(1'b0, 1'b1, 4'd0, 1'b1);
      step(1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 16 && exp_an !== 4'b1101; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (seg !== 7'b1111111 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clr_wins: seg=%b ovf=%b, want seg=1111111 ovf=0", seg, overflow);
      end
   endtask

   task automatic test_rst_midscan;
      for (int i = 0; i < 16 && exp_an !== 4'b1011; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 1'b0);
      checks++;
      if (an !== 4'b1111 || seg !== 7'h7F) begin
         errors++;
         $display("FAIL rst_midscan: an=%b seg=%b, want an=1111 seg=1111111", an, seg);
      end
      step(1'b0, 1'b0, 4'd2, 1'b0);
      checks++;
      if (an !== 4'b1110 || seg !== 7'b0100100) begin
         errors++;
         $display("FAIL rst_restart: an=%b seg=%b, want an=1110 seg=0100100", an, seg);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4,
              4'($urandom_range(0, 15)), $urandom_range(0, 49) == 0);
         checks++;
         if (an !== exp_an || seg !== exp_seg || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL random[%0d]: an=%b seg=%b ovf=%b, want %b %b %b", i, an, seg, overflow, exp_an, exp_seg, exp_ovf);
         end
      end
   endtask

   initial begin
      test_reset;
      test_pulses;
      test_hold;
      test_overflow;
      test_decode;
      test_clr_event;
      test_rst_midscan;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
